// File: rtl/toe_conn_pkg.sv
// Shared types and constants for the TOE connection table (writer and searcher).
package toe_conn_pkg;

   localparam int ENTRY_W = 145;

   typedef struct packed {
      logic [31:0] ip_src;
      logic [31:0] ip_dst;
      logic [23:0] mac_src;
      logic [23:0] mac_dst;
      logic [15:0] port_src;
      logic [15:0] port_dst;
   } conn_tuple_t;

   typedef enum logic [1:0] {
      RQ_NONE   = 2'b00,
      RQ_INSERT = 2'b01,
      RQ_DELETE = 2'b10,
      RQ_CLEAR  = 2'b11
   } conn_req_e;

   localparam logic [7:0] ERR_OK        = 8'h00;
   localparam logic [7:0] ERR_FULL      = 8'h01;
   localparam logic [7:0] ERR_BAD_ID    = 8'h02;
   localparam logic [7:0] ERR_NOT_VALID = 8'h03;
   localparam logic [7:0] ID_NONE       = 8'hFF;

   // RAM word layout: valid flag above the packed tuple.
   function automatic logic [ENTRY_W-1:0] conn_entry(input logic valid, input conn_tuple_t t);
      return {valid, t};
   endfunction

endpackage

// File: rtl/conn_table_writer_if.sv
// Request/response and RAM write bus of the connection-table writer.
interface conn_table_writer_if
   import toe_conn_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) ();
   logic [1:0]         cw_rq;
   logic [7:0]         cw_id_in;
   logic [31:0]        cw_ip_src;
   logic [31:0]        cw_ip_dst;
   logic [23:0]        cw_mac_src;
   logic [23:0]        cw_mac_dst;
   logic [15:0]        cw_port_src;
   logic [15:0]        cw_port_dst;
   logic [7:0]         cw_error;
   logic               cw_done;
   logic               cw_busy;
   logic [7:0]         cw_id_out;
   logic               cw_ram_we;
   logic [ADDR_W-1:0]  cw_ram_addr;
   logic [ENTRY_W-1:0] cw_ram_wdata;
   logic [DEPTH-1:0]   cw_valid_map;

   modport master (
      output cw_rq, cw_id_in, cw_ip_src, cw_ip_dst, cw_mac_src, cw_mac_dst,
             cw_port_src, cw_port_dst,
      input  cw_error, cw_done, cw_busy, cw_id_out, cw_ram_we, cw_ram_addr,
             cw_ram_wdata, cw_valid_map
   );

   modport slave (
      input  cw_rq, cw_id_in, cw_ip_src, cw_ip_dst, cw_mac_src, cw_mac_dst,
             cw_port_src, cw_port_dst,
      output cw_error, cw_done, cw_busy, cw_id_out, cw_ram_we, cw_ram_addr,
             cw_ram_wdata, cw_valid_map
   );
endinterface

// File: rtl/conn_free_slot_enc.sv
// Lowest-index free slot finder over the valid bitmap.
module conn_free_slot_enc #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]  valid_map_i,
   output logic [ADDR_W-1:0] slot_o,
   output logic              full_o
);
   always_comb begin
      slot_o = '0;
      full_o = 1'b1;
      // Scan downwards so the lowest zero bit is the last one to win.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_map_i[i]) begin
            slot_o = ADDR_W'(i);
            full_o = 1'b0;
         end
      end
   end
endmodule

// File: rtl/conn_table_writer.sv
// Write side of the connection table: insert / delete-by-id / clear-all plus valid bitmap.
module conn_table_writer
   import toe_conn_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input logic                cw_clk,
   input logic                cw_rst,
   conn_table_writer_if.slave cw
);
   typedef enum logic [2:0] {ST_IDLE, ST_ALLOC, ST_WRITE, ST_CLEAR, ST_DONE} state_e;

   state_e             state_q;
   conn_req_e          op_q;
   conn_tuple_t        tuple_q;
   logic [7:0]         id_q;
   logic [7:0]         pend_err_q;
   logic [7:0]         error_q;
   logic [7:0]         id_out_q;
   logic               done_q;
   logic               busy_q;
   logic               ram_we_q;
   logic [ADDR_W-1:0]  ram_addr_q;
   logic [ENTRY_W-1:0] ram_wdata_q;
   logic [DEPTH-1:0]   valid_map_q;

   conn_req_e          rq_d;
   logic [ADDR_W-1:0]  del_idx_d;
   logic [7:0]         del_err_d;
   logic [ADDR_W-1:0]  free_slot_d;
   logic               table_full_d;

   assign rq_d      = conn_req_e'(cw.cw_rq);
   assign del_idx_d = cw.cw_id_in[ADDR_W-1:0];

   // Delete legality is decided at acceptance so the write strobe can be registered.
   always_comb begin
      del_err_d = ERR_OK;
      if (int'(cw.cw_id_in) >= DEPTH) begin
         del_err_d = ERR_BAD_ID;
      end else if (!valid_map_q[del_idx_d]) begin
         del_err_d = ERR_NOT_VALID;
      end
   end

   conn_free_slot_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_free_slot (
      .valid_map_i (valid_map_q),
      .slot_o      (free_slot_d),
      .full_o      (table_full_d)
   );

   always_ff @(posedge cw_clk or negedge cw_rst) begin
      if (!cw_rst) begin
         state_q     <= ST_IDLE;
         op_q        <= RQ_NONE;
         tuple_q     <= '0;
         id_q        <= '0;
         pend_err_q  <= '0;
         error_q     <= '0;
         id_out_q    <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         valid_map_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rq_d != RQ_NONE) begin
                  busy_q  <= 1'b1;
                  op_q    <= rq_d;
                  id_q    <= cw.cw_id_in;
                  tuple_q <= '{cw.cw_ip_src, cw.cw_ip_dst, cw.cw_mac_src,
                               cw.cw_mac_dst, cw.cw_port_src, cw.cw_port_dst};
                  case (rq_d)
                     RQ_INSERT: state_q <= ST_ALLOC;
                     RQ_DELETE: begin
                        state_q    <= ST_WRITE;
                        pend_err_q <= del_err_d;
                        if (del_err_d == ERR_OK) begin
                           ram_we_q    <= 1'b1;
                           ram_addr_q  <= del_idx_d;
                           ram_wdata_q <= '0;
                        end
                     end
                     default: begin
                        state_q     <= ST_CLEAR;
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= '0;
                        ram_wdata_q <= '0;
                     end
                  endcase
               end
            end
            ST_ALLOC: begin
               if (table_full_d) begin
                  error_q  <= ERR_FULL;
                  id_out_q <= ID_NONE;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end else begin
                  ram_we_q    <= 1'b1;
                  ram_addr_q  <= free_slot_d;
                  ram_wdata_q <= conn_entry(1'b1, tuple_q);
                  pend_err_q  <= ERR_OK;
                  state_q     <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               ram_we_q <= 1'b0;
               if (op_q == RQ_INSERT) begin
                  valid_map_q[ram_addr_q] <= 1'b1;
                  id_out_q                <= 8'(ram_addr_q);
               end else begin
                  if (pend_err_q == ERR_OK) begin
                     valid_map_q[ram_addr_q] <= 1'b0;
                  end
                  id_out_q <= id_q;
               end
               error_q <= pend_err_q;
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_CLEAR: begin
               valid_map_q <= '0;
               if (ram_addr_q == ADDR_W'(DEPTH - 1)) begin
                  ram_we_q <= 1'b0;
                  error_q  <= ERR_OK;
                  id_out_q <= ID_NONE;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end else begin
                  ram_addr_q <= ram_addr_q + ADDR_W'(1);
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cw.cw_error     = error_q;
   assign cw.cw_done      = done_q;
   assign cw.cw_busy      = busy_q;
   assign cw.cw_id_out    = id_out_q;
   assign cw.cw_ram_we    = ram_we_q;
   assign cw.cw_ram_addr  = ram_addr_q;
   assign cw.cw_ram_wdata = ram_wdata_q;
   assign cw.cw_valid_map = valid_map_q;

endmodule

// File: tb/tb_conn_table_writer.sv
// Scoreboard bench for conn_table_writer: expected writes/results queued at drive time.
module tb_conn_table_writer;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conn_table_writer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

   conn_table_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .cw_clk (clk),
      .cw_rst (rst_n),
      .cw     (bus)
   );

   typedef struct { logic [3:0] addr; logic [144:0] data; } wr_t;
   typedef struct { logic [7:0] err; logic [7:0] id; int lat; logic [15:0] map; } res_t;

   wr_t         wr_q[$];
   res_t        res_q[$];
   int          total   = 0;
   int          bad     = 0;
   int          cyc     = 0;
   int          acc_cyc = 0;
   logic [15:0] mdl_map = '0;

   task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      wr_t  w;
      res_t r;
      if (rst_n) begin
         if (bus.cw_ram_we) begin
            check_val("we_expected", 160'(wr_q.size() != 0), 160'(1));
            if (wr_q.size() != 0) begin
               w = wr_q.pop_front();
               check_val("wr_addr", 160'(bus.cw_ram_addr), 160'(w.addr));
               check_val("wr_data", 160'(bus.cw_ram_wdata), 160'(w.data));
            end
         end
         if (bus.cw_done) begin
            check_val("done_expected", 160'(res_q.size() != 0), 160'(1));
            if (res_q.size() != 0) begin
               r = res_q.pop_front();
               check_val("error", 160'(bus.cw_error), 160'(r.err));
               check_val("id_out", 160'(bus.cw_id_out), 160'(r.id));
               check_val("latency", 160'(cyc - acc_cyc + 1), 160'(r.lat));
               check_val("valid_map", 160'(bus.cw_valid_map), 160'(r.map));
               $display("txn err=%02h id=%02h lat=%0d map=%04h",
                        bus.cw_error, bus.cw_id_out, cyc - acc_cyc + 1, bus.cw_valid_map);
            end
         end
      end
   end

   function automatic logic [143:0] rand_tup();
      return {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
   endfunction

   task automatic push_exp(input logic [1:0] rq, input logic [7:0] id, input logic [143:0] tup);
      res_t r;
      int   slot;
      r.err = 8'h00;
      r.id  = 8'hFF;
      r.lat = 2;
      case (rq)
         2'b01: begin
            slot = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (!mdl_map[i]) slot = i;
            if (slot < 0) begin
               r.err = 8'h01;
            end else begin
               r.id  = 8'(slot);
               r.lat = 3;
               wr_q.push_back('{addr: 4'(slot), data: {1'b1, tup}});
               mdl_map[slot] = 1'b1;
            end
         end
         2'b10: begin
            r.id = id;
            if (id >= DEPTH) r.err = 8'h02;
            else if (!mdl_map[id[3:0]]) r.err = 8'h03;
            else begin
               wr_q.push_back('{addr: id[3:0], data: '0});
               mdl_map[id[3:0]] = 1'b0;
            end
         end
         default: begin
            for (int a = 0; a < DEPTH; a++) wr_q.push_back('{addr: 4'(a), data: '0});
            mdl_map = '0;
            r.lat   = DEPTH + 1;
         end
      endcase
      r.map = mdl_map;
      res_q.push_back(r);
   endtask

   task automatic drive(input logic [1:0] rq, input logic [7:0] id, input logic [143:0] tup);
      @(negedge clk);
      bus.cw_rq       = rq;
      bus.cw_id_in    = id;
      bus.cw_ip_src   = tup[143:112];
      bus.cw_ip_dst   = tup[111:80];
      bus.cw_mac_src  = tup[79:56];
      bus.cw_mac_dst  = tup[55:32];
      bus.cw_port_src = tup[31:16];
      bus.cw_port_dst = tup[15:0];
      @(posedge clk);
      #1;
      acc_cyc         = cyc;
      bus.cw_rq       = 2'b00;
      bus.cw_id_in    = 8'($urandom());
      bus.cw_ip_src   = $urandom();
      bus.cw_port_dst = 16'($urandom());
      @(negedge clk);
      check_val("busy_after_accept", 160'(bus.cw_busy), 160'(1));
   endtask

   task automatic wait_done(input int inject);
      int n = 0;
      while (res_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
         if (inject != 0 && n == inject) bus.cw_rq = 2'b01;
         else if (inject != 0 && n == inject + 1) bus.cw_rq = 2'b00;
      end
      check_val("done_timeout", 160'(res_q.size()), 160'(0));
      @(negedge clk);
      check_val("busy_after_done", 160'(bus.cw_busy), 160'(0));
      check_val("writes_left", 160'(wr_q.size()), 160'(0));
   endtask

   task automatic request(input logic [1:0] rq, input logic [7:0] id, input logic [143:0] tup,
                          input int inject);
      push_exp(rq, id, tup);
      drive(rq, id, tup);
      wait_done(inject);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_done"},  160'(bus.cw_done),      160'(0));
      check_val({tag, "_busy"},  160'(bus.cw_busy),      160'(0));
      check_val({tag, "_we"},    160'(bus.cw_ram_we),    160'(0));
      check_val({tag, "_addr"},  160'(bus.cw_ram_addr),  160'(0));
      check_val({tag, "_wdata"}, 160'(bus.cw_ram_wdata), 160'(0));
      check_val({tag, "_error"}, 160'(bus.cw_error),     160'(0));
      check_val({tag, "_idout"}, 160'(bus.cw_id_out),    160'(0));
      check_val({tag, "_map"},   160'(bus.cw_valid_map), 160'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [143:0] t0;
      bus.cw_rq = '0; bus.cw_id_in = '0;
      bus.cw_ip_src = '0; bus.cw_ip_dst = '0;
      bus.cw_mac_src = '0; bus.cw_mac_dst = '0;
      bus.cw_port_src = '0; bus.cw_port_dst = '0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      t0 = {32'hC0A80001, 32'hC0A80002, 24'h000A01, 24'h000B02, 16'h1234, 16'h0050};
      request(2'b01, 8'h00, t0, 0);
      for (int i = 1; i < DEPTH; i++) request(2'b01, 8'h00, rand_tup(), 0);
      request(2'b01, 8'h00, rand_tup(), 0);

      request(2'b10, 8'd5, rand_tup(), 0);
      request(2'b01, 8'h00, rand_tup(), 0);

      request(2'b11, 8'h00, rand_tup(), 5);

      request(2'b10, 8'd20, rand_tup(), 0);
      request(2'b10, 8'd3, rand_tup(), 0);

      request(2'b01, 8'h00, rand_tup(), 0);
      request(2'b01, 8'h00, rand_tup(), 0);
      push_exp(2'b11, 8'h00, '0);
      drive(2'b11, 8'h00, '0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("abort");
      wr_q.delete();
      res_q.delete();
      mdl_map = '0;
      @(negedge clk);
      rst_n = 1'b1;
      request(2'b01, 8'h00, rand_tup(), 0);
      request(2'b01, 8'h00, rand_tup(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/conn_table_writer.md
Name: conn_table_writer

Overview:
Owns the write side of the TOE connection table RAM.
- Inserts new connection tuples (IP/MAC/port, src/dst) into the first free slot and returns the allocated slot id.
- Deletes entries by id, or clears the whole table.
- Exports a valid-slot bitmap. The connection-table searcher reads the same RAM and qualifies hits with this bitmap.

Parameters:
DEPTH, 16, number of connection slots (power of 2, 2..256)
ADDR_W, $clog2(DEPTH), slot address width
ENTRY_W, 145, RAM word: bit 144 valid flag, bits 143:0 packed tuple

Ports:
cw_clk  in  1  clock
cw_rst  in  1  asynchronous reset, active-low
cw_rq  in  2  request code: 00 none, 01 insert, 10 delete, 11 clear-all
cw_id_in  in  8  slot id for delete
cw_ip_src  in  32  tuple field
cw_ip_dst  in  32  tuple field
cw_mac_src  in  24  tuple field
cw_mac_dst  in  24  tuple field
cw_port_src  in  16  tuple field
cw_port_dst  in  16  tuple field
cw_error  out  8  result code, valid with cw_done
cw_done  out  1  one-cycle completion pulse
cw_busy  out  1  high while a request is in progress
cw_id_out  out  8  allocated or deleted slot id, valid with cw_done
cw_ram_we  out  1  RAM write enable
cw_ram_addr  out  ADDR_W  RAM write address
cw_ram_wdata  out  ENTRY_W  RAM write data
cw_valid_map  out  DEPTH  bit i = slot i holds a live connection

Behaviour:
- Reset (cw_rst low, asynchronous): state IDLE; all outputs 0; cw_valid_map all 0. RAM contents are not touched; the zeroed map invalidates them.
- Tuple packing, MSB first:
  - ip_src, ip_dst, mac_src, mac_dst, port_src, port_dst → bits 143:0.
  - Insert writes valid=1. Delete and clear write an all-zero word.
- Request acceptance:
  - cw_rq is sampled on a clock edge only in IDLE.
  - Inputs are registered at acceptance. Input changes afterwards have no effect.
  - A non-zero cw_rq while busy is ignored: no done pulse, no error, no queuing.
- cw_busy is high from the cycle after acceptance through the DONE cycle inclusive.
- States: IDLE, ALLOC, WRITE, CLEAR, DONE.
- Insert (01): IDLE→ALLOC.
  - ALLOC registers the lowest-index zero bit of cw_valid_map.
  - If no free slot: error=01, id_out=FF, go to DONE with no write.
  - Else go to WRITE: cw_ram_we=1 for exactly one cycle; the valid_map bit is set on that edge. Then DONE with error=00, id_out=slot.
  - Latency: cw_done is high in the 3rd cycle after the accepting edge.
- Delete (10): IDLE→WRITE checks.
  - If id_in ≥ DEPTH: error=02, no write.
  - Else if the slot is not valid: error=03, no write.
  - Else write a zero word and clear the map bit.
  - Then DONE, with id_out=id_in. Latency: done in 2nd cycle.
- Clear-all (11): IDLE→CLEAR.
  - Writes zero to addresses 0..DEPTH-1, one per cycle, cw_ram_we held high.
  - cw_valid_map is cleared entirely on the first CLEAR edge.
  - Then DONE with error=00, id_out=FF. Latency: done in cycle DEPTH+1.
- DONE lasts one cycle: cw_done=1, then return to IDLE.
  - cw_error and cw_id_out hold their values until the next done.
- Insert into a slot that was just deleted: allowed immediately; the lowest free index wins.
- Address counter wraps only at DEPTH-1; no write beyond the table.
- Reset during WRITE/CLEAR aborts immediately: cw_ram_we drops asynchronously and the map is cleared.

Decomposition:
- Package toe_conn_pkg:
  - conn_tuple_t packed struct (144 bits).
  - Request code enum.
  - Error constants: ERR_OK=00, ERR_FULL=01, ERR_BAD_ID=02, ERR_NOT_VALID=03.
  - Shared with the connection-table searcher.
- Sub-module conn_free_slot_enc: combinational lowest-zero priority encoder over cw_valid_map, outputs slot index plus a full flag.

Test Plan:
- Reset, then insert {ip_src=C0A80001, ip_dst=C0A80002, ports 1234/0050} → done in 3rd cycle, error=00, id_out=00, one we pulse at addr 0, wdata[144]=1, valid_map=0001.
- 16 inserts, then a 17th → 17th gives error=01, id_out=FF, no we, valid_map=FFFF.
- Delete id 5 after a full table; then insert → delete gives error=00 with a zero word at addr 5; insert returns id_out=05.
- Delete id 20 and delete an unused id 3 on an empty table → error=02 and 03 respectively, no we.
- Clear-all with a full table → we high for 16 cycles at addresses 0..15, valid_map=0000, done in cycle 17; a request driven mid-clear is ignored.
- Assert reset mid-clear → we drops immediately, all outputs 0; a subsequent insert returns id 00.
